// File: rtl/data_path.sv
// Datapath for the clock/timer controller: fast counter s, slow counter y,
// the y_inc rollover flag back to the FSM and a registered y wrap pulse.
module data_path #(
  parameter int unsigned SW     = 3,
  parameter int unsigned YW     = 4,
  parameter int unsigned S_WRAP = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [YW-1:0] x,
  input  logic          s_en,
  input  logic          s_add,
  input  logic [1:0]    s_step,
  input  logic          s_zero,
  input  logic          y_en,
  input  logic          y_store_x,
  input  logic [1:0]    y_select_next,
  output logic          y_inc,
  output logic [SW-1:0] s,
  output logic [YW-1:0] y,
  output logic          y_carry
);

  localparam logic [SW:0]   WRAP_W   = (SW+1)'(S_WRAP);
  localparam logic [SW-1:0] S_LAST   = SW'(S_WRAP - 1);
  localparam logic [YW-1:0] Y_MAX    = '1;

  localparam logic [1:0] Y_HOLD = 2'd0;
  localparam logic [1:0] Y_INC  = 2'd1;
  localparam logic [1:0] Y_DEC  = 2'd2;
  localparam logic [1:0] Y_CLR  = 2'd3;

  logic [SW-1:0] s_q, s_d;
  logic [YW-1:0] y_q, y_d;
  logic          y_carry_q, y_carry_d;

  logic [SW-1:0] s_base;
  logic [SW:0]   s_sum;
  logic [SW:0]   s_sum_wrapped;

  always_comb begin
    s_base        = s_zero ? '0 : s_q;
    s_sum         = {1'b0, s_base} + (SW+1)'(s_step);
    s_sum_wrapped = s_sum - WRAP_W;
    s_d           = s_q;
    if (s_en) begin
      if (s_add) begin
        // Only one subtraction of the modulus; out-of-range s is not corrected further
        s_d = (s_sum >= WRAP_W) ? s_sum_wrapped[SW-1:0] : s_sum[SW-1:0];
      end else begin
        s_d = s_base - SW'(s_step);
      end
    end
  end

  always_comb begin
    y_d       = y_q;
    y_carry_d = 1'b0;
    if (y_en) begin
      if (y_store_x) begin
        y_d = x;
      end else begin
        unique case (y_select_next)
          Y_HOLD: y_d = y_q;
          Y_INC: begin
            y_d       = y_q + 1'b1;
            y_carry_d = (y_q == Y_MAX);
          end
          Y_DEC: begin
            y_d       = y_q - 1'b1;
            y_carry_d = (y_q == '0);
          end
          Y_CLR: y_d = '0;
          default: y_d = y_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= '0;
      y_q       <= '0;
      y_carry_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      y_q       <= y_d;
      y_carry_q <= y_carry_d;
    end
  end

  assign y_inc   = (s_q == S_LAST);
  assign s       = s_q;
  assign y       = y_q;
  assign y_carry = y_carry_q;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios followed by random
// commands compared against an integer-arithmetic reference model.
module tb_data_path;

  localparam int SW = 3;
  localparam int YW = 4;
  localparam int S_WRAP = 3;
  localparam int S_MOD = 1 << SW;
  localparam int Y_MOD = 1 << YW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [YW-1:0] x = '0;
  logic          s_en = 1'b0, s_add = 1'b0, s_zero = 1'b0;
  logic [1:0]    s_step = '0;
  logic          y_en = 1'b0, y_store_x = 1'b0;
  logic [1:0]    y_select_next = '0;
  logic          y_inc, y_carry;
  logic [SW-1:0] s;
  logic [YW-1:0] y;

  int checks = 0;
  int failures = 0;

  int m_s = 0, m_y = 0, m_c = 0;

  data_path #(.SW(SW), .YW(YW), .S_WRAP(S_WRAP)) dut (
    .clk(clk), .rst(rst), .x(x),
    .s_en(s_en), .s_add(s_add), .s_step(s_step), .s_zero(s_zero),
    .y_en(y_en), .y_store_x(y_store_x), .y_select_next(y_select_next),
    .y_inc(y_inc), .s(s), .y(y), .y_carry(y_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".s"}, 32'(s), 32'(m_s));
    chk({tag, ".y"}, 32'(y), 32'(m_y));
    chk({tag, ".y_carry"}, 32'(y_carry), 32'(m_c));
    chk({tag, ".y_inc"}, 32'(y_inc), 32'(m_s == S_WRAP - 1));
  endtask

  // Reference: apply the command set presented to the DUT to the model state.
  task automatic model_edge();
    int base, sum, ns, ny, nc;
    ns = m_s; ny = m_y; nc = 0;
    if (s_en) begin
      base = s_zero ? 0 : m_s;
      if (s_add) begin
        sum = base + int'(s_step);
        ns  = (sum >= S_WRAP) ? (sum - S_WRAP) % S_MOD : sum;
      end else begin
        ns = (base - int'(s_step) + S_MOD) % S_MOD;
      end
    end
    if (y_en) begin
      if (y_store_x) ny = int'(x);
      else case (y_select_next)
        2'd1: begin ny = (m_y + 1) % Y_MOD; nc = (m_y == Y_MOD - 1); end
        2'd2: begin ny = (m_y + Y_MOD - 1) % Y_MOD; nc = (m_y == 0); end
        2'd3: ny = 0;
        default: ny = m_y;
      endcase
    end
    m_s = ns; m_y = ny; m_c = nc;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic idle();
    s_en = 0; s_add = 0; s_step = 0; s_zero = 0;
    y_en = 0; y_store_x = 0; y_select_next = 0;
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    m_s = 0; m_y = 0; m_c = 0;
    chk_all({tag, ".imm"});
    @(posedge clk); #1;
    chk_all({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    idle();
    #1;
    chk_all("por");
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all("reset_idle");

    // Build s=2, y=9 then reset asynchronously between edges.
    s_en = 1; s_add = 1; s_zero = 1; s_step = 2;
    y_en = 1; y_store_x = 1; x = 4'd9;
    tick("setup");
    idle();
    async_reset("async_rst");

    // Countdown 6,4,2,0
    s_en = 1; s_add = 0; s_step = 2; s_zero = 1;
    tick("cd0");
    chk("cd0.lit", 32'(s), 32'd6);
    s_zero = 0;
    tick("cd1");
    tick("cd2");
    tick("cd3");
    chk("cd3.lit", 32'(s), 32'd0);

    // Count mode with y incremented on s rollover
    s_add = 1; s_step = 1; y_select_next = 2'd1;
    for (int i = 0; i < 6; i++) begin
      y_en = (m_s == S_WRAP - 1);
      tick("count");
    end
    chk("count.y_lit", 32'(y), 32'd2);
    idle();

    // Preset priority then decrement
    x = 4'd11; y_en = 1; y_store_x = 1; y_select_next = 2'd3;
    tick("preset");
    chk("preset.lit", 32'(y), 32'd11);
    y_store_x = 0; y_select_next = 2'd2;
    tick("preset_dec");
    chk("preset_dec.lit", 32'(y), 32'd10);

    // Wrap pulses
    x = 4'd15; y_store_x = 1;
    tick("load15");
    y_store_x = 0; y_select_next = 2'd1;
    tick("wrap_inc");
    chk("wrap_inc.lit", 32'(y_carry), 32'd1);
    y_en = 0;
    tick("wrap_pulse_end");
    y_en = 1; y_select_next = 2'd2;
    tick("wrap_dec");
    chk("wrap_dec.y_lit", 32'(y), 32'd15);
    y_select_next = 2'd3;
    tick("clear15");
    chk("clear15.lit", 32'(y_carry), 32'd0);
    y_select_next = 2'd2;
    tick("wrap_dec2");
    tick("no_wrap_dec");

    // Out-of-range s in add mode: 6 + 1 -> 4
    idle();
    s_en = 1; s_add = 0; s_zero = 1; s_step = 2;
    tick("oor_setup");
    s_add = 1; s_zero = 0; s_step = 1;
    tick("oor_add");
    chk("oor_add.lit", 32'(s), 32'd4);

    // Concurrent: s=2, y=5
    s_zero = 1; s_step = 2; y_en = 1; y_store_x = 1; x = 4'd5;
    tick("conc_setup");
    s_zero = 0; s_step = 1; y_store_x = 0; y_select_next = 2'd1;
    tick("concurrent");
    chk("concurrent.s_lit", 32'(s), 32'd0);
    chk("concurrent.y_lit", 32'(y), 32'd6);

    // Random commands
    for (int i = 0; i < 400; i++) begin
      s_en = 1'($urandom); s_add = 1'($urandom); s_zero = ($urandom_range(0, 5) == 0);
      s_step = 2'($urandom);
      y_en = 1'($urandom); y_store_x = ($urandom_range(0, 7) == 0);
      y_select_next = 2'($urandom_range(0, 9) < 8 ? $urandom_range(1, 2) : $urandom_range(0, 3));
      x = 4'($urandom);
      tick("rand");
      if (i % 97 == 96) async_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_path.md
# data_path

Datapath companion to the clock/timer control FSM. It holds the fast counter `s` and the slow counter `y`. It applies the per-cycle update commands issued by the control FSM (`s_en`/`s_add`/`s_step`/`s_zero`, `y_en`/`y_store_x`/`y_select_next`) and returns the `y_inc` status flag that tells the FSM when an `s` increment will roll over into `y`. It also exports `s`, `y` and a registered `y` overflow pulse to the display/output logic.

## Interface
- `SW`, 3: width of `s`.
- `YW`, 4: width of `y` and `x`.
- `S_WRAP`, 3: modulus of `s` in add mode; legal range 2..2^SW.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `x`  in  YW  external preset value for `y`.
- `s_en`  in  1  enable `s` update this cycle.
- `s_add`  in  1  1 = add step (modulo `S_WRAP`); 0 = subtract step (modulo 2^SW).
- `s_step`  in  2  step magnitude, 0..3.
- `s_zero`  in  1  1 = use 0 instead of current `s` as operand base.
- `y_en`  in  1  enable `y` update this cycle.
- `y_store_x`  in  1  1 = load `x` into `y` (overrides `y_select_next`).
- `y_select_next`  in  2  `y` operation: 0 hold, 1 increment, 2 decrement, 3 clear.
- `y_inc`  out  1  combinational; 1 iff `s == S_WRAP-1`.
- `s`  out  SW  current fast counter.
- `y`  out  YW  current slow counter.
- `y_carry`  out  1  registered one-cycle pulse on `y` wrap (increment from max or decrement from 0).

## Operation
- **Reset** (`rst` high, asynchronous): `s`=0, `y`=0, `y_carry`=0. This holds regardless of `clk`, and holds while `rst` stays high.
- **`s` update** (only when `s_en`=1 at the edge):
  - `base` = `s_zero` ? 0 : `s`.
  - Add mode: `sum` = `base` + `s_step`, computed SW+1 bits wide. If `sum` ≥ `S_WRAP`, `s` ← `sum` − `S_WRAP`; otherwise `s` ← `sum`.
  - Subtract mode: `s` ← (`base` − `s_step`) mod 2^SW, natural wrap. With SW=3: 0−2=6, 6−2=4, 4−2=2, 2−2=0. The countdown regime relies on this sequence.
- **`s` hold**: when `s_en`=0, `s` holds and the remaining s-controls are ignored.
- **`y` update** (only when `y_en`=1 at the edge):
  - If `y_store_x`=1: `y` ← `x`.
  - Else by `y_select_next`: 0 hold; 1 `y`+1 mod 2^YW; 2 `y`−1 mod 2^YW; 3 `y` ← 0.
- **`y` hold**: when `y_en`=0, `y` holds.
- **`y_carry`**: set to 1 for exactly the cycle after an edge where `y` wrapped. A wrap is an increment from 2^YW−1 or a decrement from 0. `y_carry` is 0 after every other edge. Loads and clears never assert it.
- **Simultaneous events**: `s` and `y` updates are independent and may occur on the same edge. Each uses pre-edge values of `s`/`y`.
- **`y_inc` source**: `y_inc` is derived from the registered `s` only, never from next-state values.
- **Out-of-range `s`**: if `s` ≥ `S_WRAP` in add mode (e.g. after a subtract-mode countdown), the rule above still applies. Example: `s`=6, step 1, `S_WRAP`=3 → `sum`=7 → `s`=4. The block applies no further correction.

## Timing
- All register updates take effect at the rising edge where the enables are sampled; outputs `s`/`y` reflect them in the following cycle.
- `y_inc` is combinational from `s`, valid the whole cycle after `s` settles. The FSM samples it the same cycle.
- `y_carry` has one-cycle latency after the wrapping edge and a width of exactly one cycle, unless `y` wraps on consecutive edges, in which case it stays high.
- Reset deasserted mid-operation: the first edge after deassertion applies normal commands from the zero state.
- There is no handshake and no backpressure; every command is accepted in the cycle it is presented.

## Test plan
- **Reset**: drive `rst` high asynchronously between edges with `s`=2, `y`=9 → `s`=0, `y`=0, `y_carry`=0 immediately; `y_inc`=0.
- **Countdown**: `s_en`=1, `s_add`=0, `s_step`=2, `s_zero`=1 for one cycle, then `s_zero`=0 for 3 cycles → `s` sequence 6, 4, 2, 0.
- **Count mode**: from `s`=0, `s_en`=1, `s_add`=1, `s_step`=1 each cycle; when `y_inc`=1, also `y_en`=1, `y_select_next`=1 → `s` 1, 2, 0, 1, 2, 0; `y` increments once per `s` rollover (0→1→2); `y_inc` high exactly when `s`=2.
- **Preset and priority**: `x`=11, `y_en`=1, `y_store_x`=1, `y_select_next`=3 → `y`=11; next cycle `y_store_x`=0, `y_select_next`=2 → `y`=10.
- **Wrap pulse**: `y`=15, increment → `y`=0, `y_carry`=1 for one cycle. Decrement from 0 → `y`=15, `y_carry`=1. Clear with `y`=15 → `y_carry`=0.
- **Concurrent updates**: `s`=2, `y`=5, both enables high, `s` add step 1, `y` increment → `s`=0, `y`=6 on the same edge.
